// File: rtl/pipeline_pkg.sv
// Shared encodings and widths for the MEM stage and its lane-alignment helper.
package pipeline_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned BE_W       = DATA_W / 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data bus: store enables/replication, load extraction/extension.
module mem_lane_align
  import pipeline_pkg::*;
(
  input  logic [1:0]        addr_lo_i,
  input  logic [1:0]        size_i,
  input  logic              load_unsigned_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [BE_W-1:0]   be_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              misalign_o
);

  logic [DATA_W-1:0] lane;

  // Shift the addressed lane down to bit 0 before extension.
  assign lane = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    be_o        = 4'b1111;
    wdata_o     = store_data_i;
    load_data_o = lane;
    misalign_o  = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        be_o        = 4'b0001 << addr_lo_i;
        wdata_o     = {4{store_data_i[7:0]}};
        load_data_o = load_unsigned_i ? {24'b0, lane[7:0]}
                                      : {{24{lane[7]}}, lane[7:0]};
      end
      SZ_HALF: begin
        be_o        = 4'b0011 << addr_lo_i;
        wdata_o     = {2{store_data_i[15:0]}};
        load_data_o = load_unsigned_i ? {16'b0, lane[15:0]}
                                      : {{16{lane[15]}}, lane[15:0]};
        misalign_o  = addr_lo_i[0];
      end
      default: begin
        misalign_o  = |addr_lo_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs req/ack data-memory transactions and feeds the MEM/WB register.
module mem_access_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned       WAIT_LIMIT = 15,
  parameter logic [DATA_W-1:0] ERR_DATA   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     address_in,
  input  logic [DATA_W-1:0]     write_data_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic [1:0]            size_in,
  input  logic                  load_unsigned_in,
  input  logic                  reg_write_in,
  input  logic                  mem_to_reg_in,
  input  logic [REG_ADDR_W-1:0] write_back_destination_in,
  input  logic                  err_clr,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  output logic [BE_W-1:0]       dmem_be,
  input  logic [DATA_W-1:0]     dmem_rdata,
  input  logic                  dmem_ack,
  output logic                  stall_out,
  output logic [DATA_W-1:0]     read_data_out,
  output logic [DATA_W-1:0]     address_out,
  output logic                  reg_write_out,
  output logic                  mem_to_reg_out,
  output logic [REG_ADDR_W-1:0] write_back_destination_out,
  output logic                  misaligned,
  output logic                  bus_err
);

  localparam int unsigned CNT_W = $clog2(WAIT_LIMIT + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              bus_err_q, bus_err_d;

  logic              mem_op, is_store, misalign_c;
  logic              in_idle, in_busy, in_done;
  logic [BE_W-1:0]   be_c;
  logic [DATA_W-1:0] wdata_c, load_c;

  assign mem_op   = mem_read_in | mem_write_in;
  assign is_store = mem_write_in;
  assign in_busy  = (state_q == BUSY);
  assign in_done  = (state_q == DONE);
  assign in_idle  = ~in_busy & ~in_done;

  mem_lane_align u_lane (
    .addr_lo_i       (address_in[1:0]),
    .size_i          (size_in),
    .load_unsigned_i (load_unsigned_in),
    .store_data_i    (write_data_in),
    .rdata_i         (dmem_rdata),
    .be_o            (be_c),
    .wdata_o         (wdata_c),
    .load_data_o     (load_c),
    .misalign_o      (misalign_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state: a timeout in the same cycle as err_clr leaves bus_err set.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    bus_err_d = bus_err_q & ~err_clr;
    case (state_q)
      IDLE: begin
        if (mem_op && !misalign_c) begin
          state_d = BUSY;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          rdata_d = is_store ? '0 : load_c;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(WAIT_LIMIT - 1)) begin
          rdata_d   = ERR_DATA;
          err_d     = 1'b1;
          bus_err_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dmem_req   = in_busy;
  assign dmem_we    = in_busy & is_store;
  assign dmem_addr  = {address_in[DATA_W-1:2], 2'b00};
  assign dmem_wdata = wdata_c;
  assign dmem_be    = be_c;

  assign stall_out  = in_busy | (in_idle & mem_op & ~misalign_c);
  assign misaligned = in_idle & mem_op & misalign_c;
  assign bus_err    = bus_err_q;

  assign address_out                = address_in;
  assign mem_to_reg_out             = mem_to_reg_in;
  assign write_back_destination_out = write_back_destination_in;

  // Stalled cycles present a bubble to MEM/WB so the write-back fires only once, in DONE.
  always_comb begin
    read_data_out = '0;
    reg_write_out = 1'b0;
    if (in_done) begin
      read_data_out = rdata_q;
      reg_write_out = reg_write_in & ~err_q;
    end else if (in_idle) begin
      read_data_out = misaligned ? ERR_DATA : '0;
      reg_write_out = reg_write_in & ~mem_op;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] address_in, write_data_in, dmem_rdata;
  logic        mem_read_in, mem_write_in, load_unsigned_in, reg_write_in, mem_to_reg_in;
  logic [1:0]  size_in;
  logic [4:0]  write_back_destination_in;
  logic        err_clr, dmem_ack;
  logic        dmem_req, dmem_we, stall_out, reg_write_out, mem_to_reg_out, misaligned, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, read_data_out, address_out;
  logic [3:0]  dmem_be;
  logic [4:0]  write_back_destination_out;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.WAIT_LIMIT(15), .ERR_DATA(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .address_in(address_in), .write_data_in(write_data_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .size_in(size_in), .load_unsigned_in(load_unsigned_in),
    .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .write_back_destination_in(write_back_destination_in), .err_clr(err_clr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .stall_out(stall_out), .read_data_out(read_data_out),
    .address_out(address_out), .reg_write_out(reg_write_out),
    .mem_to_reg_out(mem_to_reg_out),
    .write_back_destination_out(write_back_destination_out),
    .misaligned(misaligned), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ops();
    mem_read_in = 1'b0; mem_write_in = 1'b0; size_in = 2'b10; load_unsigned_in = 1'b0;
    reg_write_in = 1'b0; mem_to_reg_in = 1'b0; write_back_destination_in = '0;
    address_in = '0; write_data_in = '0; dmem_ack = 1'b0; dmem_rdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; err_clr = 1'b0;
    clear_ops();
    #2;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", dmem_req); end
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", stall_out); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err: got %b exp 0", bus_err); end
    checks++; if (read_data_out !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h exp 0", read_data_out); end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_non_mem();
    logic [31:0] addrs [3] = '{32'h0000_0010, 32'h0000_0014, 32'hFFFF_FFFC};
    logic        rws   [3] = '{1'b1, 1'b0, 1'b1};
    logic [4:0]  dsts  [3] = '{5'd5, 5'd31, 5'd0};
    for (int i = 0; i < 3; i++) begin
      clear_ops();
      address_in = addrs[i]; reg_write_in = rws[i]; write_back_destination_in = dsts[i];
      mem_to_reg_in = 1'b0;
      #1;
      checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL nonmem_stall[%0d]: got %b exp 0", i, stall_out); end
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL nonmem_req[%0d]: got %b exp 0", i, dmem_req); end
      checks++; if (address_out !== addrs[i]) begin errors++; $display("FAIL nonmem_addr[%0d]: got %h exp %h", i, address_out, addrs[i]); end
      checks++; if (reg_write_out !== rws[i]) begin errors++; $display("FAIL nonmem_rw[%0d]: got %b exp %b", i, reg_write_out, rws[i]); end
      checks++; if (write_back_destination_out !== dsts[i]) begin errors++; $display("FAIL nonmem_dst[%0d]: got %0d exp %0d", i, write_back_destination_out, dsts[i]); end
      checks++; if (read_data_out !== 32'h0) begin errors++; $display("FAIL nonmem_rdata[%0d]: got %h exp 0", i, read_data_out); end
      tick();
    end
    clear_ops();
  endtask

  // Issues one access starting in IDLE and follows it to DONE; ack_after < 0 means never ack.
  task automatic run_access(input string name, input logic [31:0] addr, input logic [31:0] wd,
                            input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                            input logic rw, input logic [31:0] rdata, input int ack_after,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata, input int exp_stall,
                            input logic [31:0] exp_rd, input logic exp_rw, input logic exp_berr);
    int stall_cnt = 0;
    int busy_cnt = 0;
    bit done = 1'b0;
    logic [3:0]  be_s = '0;
    logic [31:0] wd_s = '0;
    logic [31:0] ad_s = '0;
    logic        we_s = 1'b0;
    address_in = addr; write_data_in = wd; mem_read_in = rd; mem_write_in = wr;
    size_in = sz; load_unsigned_in = uns; reg_write_in = rw; mem_to_reg_in = rd;
    write_back_destination_in = 5'd9; dmem_rdata = rdata; dmem_ack = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (!stall_out) done = 1'b1;
      else begin
        stall_cnt++;
        if (dmem_req) begin
          busy_cnt++;
          be_s = dmem_be; wd_s = dmem_wdata; we_s = dmem_we; ad_s = dmem_addr;
          if (ack_after >= 0 && busy_cnt == ack_after + 1) dmem_ack = 1'b1;
        end
        tick();
        dmem_ack = 1'b0;
      end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s_complete: got stuck stall exp release", name); end
    checks++; if (stall_cnt != exp_stall) begin errors++; $display("FAIL %s_stall_cycles: got %0d exp %0d", name, stall_cnt, exp_stall); end
    checks++; if (be_s !== exp_be) begin errors++; $display("FAIL %s_be: got %b exp %b", name, be_s, exp_be); end
    checks++; if (we_s !== wr) begin errors++; $display("FAIL %s_we: got %b exp %b", name, we_s, wr); end
    checks++; if (ad_s !== {addr[31:2], 2'b00}) begin errors++; $display("FAIL %s_addr: got %h exp %h", name, ad_s, {addr[31:2], 2'b00}); end
    if (wr) begin
      checks++; if (wd_s !== exp_wdata) begin errors++; $display("FAIL %s_wdata: got %h exp %h", name, wd_s, exp_wdata); end
    end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL %s_done_req: got %b exp 0", name, dmem_req); end
    checks++; if (read_data_out !== exp_rd) begin errors++; $display("FAIL %s_rdata: got %h exp %h", name, read_data_out, exp_rd); end
    checks++; if (reg_write_out !== exp_rw) begin errors++; $display("FAIL %s_rw: got %b exp %b", name, reg_write_out, exp_rw); end
    checks++; if (bus_err !== exp_berr) begin errors++; $display("FAIL %s_bus_err: got %b exp %b", name, bus_err, exp_berr); end
    checks++; if (write_back_destination_out !== 5'd9) begin errors++; $display("FAIL %s_dst: got %0d exp 9", name, write_back_destination_out); end
    clear_ops();
    tick();
  endtask

  task automatic test_loads();
    run_access("lb",  32'h103, 0, 1, 0, 2'b00, 0, 1, 32'h8012_3456, 0, 4'b1000, 0, 2, 32'hFFFF_FF80, 1, 0);
    run_access("lbu", 32'h103, 0, 1, 0, 2'b00, 1, 1, 32'h8012_3456, 0, 4'b1000, 0, 2, 32'h0000_0080, 1, 0);
    run_access("lb1", 32'h101, 0, 1, 0, 2'b00, 0, 1, 32'h0000_7F00, 0, 4'b0010, 0, 2, 32'h0000_007F, 1, 0);
    run_access("lh",  32'h102, 0, 1, 0, 2'b01, 0, 1, 32'h8001_1234, 1, 4'b1100, 0, 3, 32'hFFFF_8001, 1, 0);
    run_access("lhu", 32'h100, 0, 1, 0, 2'b01, 1, 1, 32'h1234_F00D, 0, 4'b0011, 0, 2, 32'h0000_F00D, 1, 0);
    run_access("lw",  32'h100, 0, 1, 0, 2'b10, 0, 1, 32'hDEAD_BEEF, 2, 4'b1111, 0, 4, 32'hDEAD_BEEF, 1, 0);
    run_access("lw11", 32'h300, 0, 1, 0, 2'b11, 0, 1, 32'h1122_3344, 0, 4'b1111, 0, 2, 32'h1122_3344, 1, 0);
  endtask

  task automatic test_stores();
    run_access("sh", 32'h202, 32'h1234_ABCD, 0, 1, 2'b01, 0, 0, 32'h0, 3, 4'b1100, 32'hABCD_ABCD, 5, 32'h0, 0, 0);
    run_access("sb", 32'h201, 32'h0000_005A, 0, 1, 2'b00, 0, 0, 32'h0, 0, 4'b0010, 32'h5A5A_5A5A, 2, 32'h0, 0, 0);
    run_access("sw", 32'h204, 32'hCAFE_F00D, 0, 1, 2'b10, 0, 0, 32'h0, 1, 4'b1111, 32'hCAFE_F00D, 3, 32'h0, 0, 0);
    run_access("rdwr", 32'h208, 32'h0102_0304, 1, 1, 2'b10, 0, 0, 32'hFFFF_FFFF, 0, 4'b1111, 32'h0102_0304, 2, 32'h0, 0, 0);
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs [4] = '{32'h301, 32'h302, 32'h203, 32'h305};
    logic [1:0]  szs   [4] = '{2'b10, 2'b10, 2'b01, 2'b10};
    logic        wrs   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      clear_ops();
      address_in = addrs[i]; size_in = szs[i]; mem_write_in = wrs[i]; mem_read_in = ~wrs[i];
      reg_write_in = 1'b1; write_data_in = 32'hFFFF_FFFF; dmem_ack = 1'b1;
      #1;
      checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_pulse[%0d]: got %b exp 1", i, misaligned); end
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL mis_req[%0d]: got %b exp 0", i, dmem_req); end
      checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL mis_stall[%0d]: got %b exp 0", i, stall_out); end
      checks++; if (reg_write_out !== 1'b0) begin errors++; $display("FAIL mis_rw[%0d]: got %b exp 0", i, reg_write_out); end
      checks++; if (read_data_out !== 32'h0) begin errors++; $display("FAIL mis_rdata[%0d]: got %h exp 0", i, read_data_out); end
      clear_ops();
      tick();
      checks++; if (misaligned !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL mis_after[%0d]: got mis=%b req=%b exp 0 0", i, misaligned, dmem_req); end
    end
  endtask

  task automatic test_timeout();
    run_access("lw_to", 32'h400, 0, 1, 0, 2'b10, 0, 1, 32'h5555_5555, -1, 4'b1111, 0, 16, 32'h0, 0, 1);
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b exp 1", bus_err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL to_clear: got %b exp 0", bus_err); end
    // err_clr held across a second timeout: the set must win on the timeout edge.
    err_clr = 1'b1;
    run_access("lw_to_clr", 32'h404, 0, 1, 0, 2'b10, 0, 1, 32'h0, -1, 4'b1111, 0, 16, 32'h0, 0, 1);
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL to_clr_after: got %b exp 0", bus_err); end
    err_clr = 1'b0;
  endtask

  task automatic test_reset_busy();
    address_in = 32'h500; mem_read_in = 1'b1; size_in = 2'b10; reg_write_in = 1'b1;
    dmem_rdata = 32'h1234_5678;
    tick();
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rst_busy_req: got %b exp 1", dmem_req); end
    rst_n = 1'b0;
    #1;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_drop_req: got %b exp 0", dmem_req); end
    clear_ops();
    dmem_rdata = 32'h1234_5678; dmem_ack = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (dmem_req !== 1'b0 || stall_out !== 1'b0) begin errors++; $display("FAIL rst_late_ack: got req=%b stall=%b exp 0 0", dmem_req, stall_out); end
    checks++; if (read_data_out !== 32'h0 || bus_err !== 1'b0 || misaligned !== 1'b0) begin errors++; $display("FAIL rst_flags: got rd=%h berr=%b mis=%b exp 0", read_data_out, bus_err, misaligned); end
    dmem_ack = 1'b0;
    tick();
    run_access("lw_post_rst", 32'h500, 0, 1, 0, 2'b10, 0, 1, 32'hA5A5_0F0F, 0, 4'b1111, 0, 2, 32'hA5A5_0F0F, 1, 0);
  endtask

  initial begin
    test_reset();
    test_non_mem();
    test_loads();
    test_stores();
    test_misaligned();
    test_timeout();
    test_reset_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
